mux_sequencer: RTL
==================

// Module: mux_sequencer
// PURPOSE
//  Upstream control stage for the N:1 word mux. Accepts one NUM_DATA-word vector plus a lane mask.
//  Walks the set mask bits in ascending lane order, driving the mux select.
//  Emits the selected words as a valid/ready stream, one word per handshake.
//  Serialises wide bus results (e.g. PE outputs) onto a single DATA_WIDTH channel.
// PARAMETERS
//  DATA_WIDTH  16  width of one data word
//  NUM_DATA    16  words per input vector; CTRL_WIDTH = `C_LOG_2(NUM_DATA)
// PORTS
//  clk        in   1                     single clock, rising edge
//  reset      in   1                     synchronous, active-high
//  IN_VALID   in   1                     input vector valid
//  IN_READY   out  1                     sequencer can accept a vector
//  IN_DATA    in   DATA_WIDTH*NUM_DATA   word i at [i*DATA_WIDTH +: DATA_WIDTH]
//  IN_MASK    in   NUM_DATA              bit i=1: lane i is emitted
//  OUT_VALID  out  1                     output word valid
//  OUT_READY  in   1                     downstream accepts word
//  OUT_DATA   out  DATA_WIDTH            selected word
//  OUT_SEL    out  CTRL_WIDTH            lane index of OUT_DATA (mux select)
//  OUT_LAST   out  1                     OUT_DATA is the final lane of the vector
// BEHAVIOUR
//  - States: IDLE, SEND. Held in IDLE while reset=1.
//    On the edge after reset, state=IDLE; data/mask regs, OUT_SEL, OUT_VALID and OUT_LAST are 0.
//  - IN_READY = (state==IDLE) & ~reset. Combinational from state only; no dependence on IN_VALID.
//  - IDLE, IN_VALID&IN_READY:
//      * capture IN_DATA -> data_q and IN_MASK -> mask_q.
//      * mask!=0: next state SEND; OUT_SEL <= index of lowest set bit; OUT_VALID <= 1.
//      * mask==0: vector dropped, stays IDLE, no output produced.
//  - SEND: OUT_VALID=1; OUT_DATA = data_q[OUT_SEL] via the mux sub-module.
//    OUT_LAST = (mask_q with bit OUT_SEL cleared) == 0.
//  - SEND, OUT_VALID&OUT_READY:
//      * clear mask_q[OUT_SEL].
//      * not last: OUT_SEL <= next-lowest set bit, stay SEND.
//      * last: OUT_VALID <= 0, go to IDLE.
//  - SEND, ~OUT_READY: OUT_DATA, OUT_SEL and OUT_LAST are held stable. No word is skipped or repeated.
//  - Latency: vector accepted on edge t -> first word valid from cycle t+1.
//    Throughput: popcount(mask) words, then 1 IDLE bubble before the next accept.
//    No same-cycle last-out/next-in overlap.
//  - Lanes >= NUM_DATA do not exist; OUT_SEL never exceeds NUM_DATA-1.
//  - Reset mid-SEND: remaining lanes discarded. OUT_VALID=0 after the reset edge, and no partial resume.
//  - OUT_DATA is driven only from registers (data_q, OUT_SEL); there is no input-to-output combinational path.
// STRUCTURE
//  - Shared header: `C_LOG_2 from log.vh; state encodings IDLE=1'b0, SEND=1'b1 as localparams.
//  - Function lowest_set(mask) -> CTRL_WIDTH index, an LSB-first priority encoder.
//    It lives in the shared include so other sequencers reuse it.
//  - Sub-module: one instance of the existing mux.
//    Ports: DATA_IN=data_q, CTRL_IN=OUT_SEL, DATA_OUT=OUT_DATA.
// TESTING (DATA_WIDTH=16, NUM_DATA=16, word i = 16'h1000+i)
//  1. Full vector:
//     mask=16'hFFFF, OUT_READY=1 -> 16 words 0x1000..0x100F, OUT_SEL 0..15.
//     OUT_LAST only on 0x100F; IN_READY high again 1 cycle after.
//  2. Sparse vector:
//     mask=16'h8421 -> words 0x1000, 0x1005, 0x100A, 0x100F.
//     OUT_LAST only with OUT_SEL=15.
//  3. Backpressure:
//     mask=16'h0006, OUT_READY toggled 0,0,1,0,1 -> 0x1001 held 3 cycles, then 0x1002 held until ready.
//     Exactly 2 handshakes.
//  4. Empty/single mask:
//     mask=0 -> no OUT_VALID; IN_READY stays 1.
//     mask=16'h0010 -> one word 0x1004 with OUT_LAST=1.
//  5. Reset mid-burst:
//     mask=16'hFFFF, assert reset after 3rd handshake -> OUT_VALID=0 next cycle.
//     Next vector (mask=16'h0003) emits 0x1000, 0x1001 only.
//  6. IN_VALID while SEND: IN_READY=0; the input is not captured, and the in-flight words are unchanged.

Source files
------------

// File: rtl/mux_sequencer_pkg.sv
// Shared types and helpers for the mux sequencer family: state encoding, select-width
// calculation and an LSB-first priority encoder reusable by other sequencers.
package mux_sequencer_pkg;

  // Widest lane mask the shared priority encoder handles.
  localparam int unsigned MaxLanes = 64;

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_e;

  function automatic int unsigned ctrl_width(input int unsigned num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic int unsigned lowest_set(input logic [MaxLanes-1:0] mask);
    int unsigned idx;
    idx = 0;
    for (int i = MaxLanes - 1; i >= 0; i--) begin
      if (mask[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_sequencer_if.sv
// Vector-in / word-out stream bundle between a producer/consumer (master) and the
// mux sequencer (slave).
interface mux_sequencer_if #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned NumData   = 16
);
  localparam int unsigned CtrlWidth = mux_sequencer_pkg::ctrl_width(NumData);

  logic                          in_valid;
  logic                          in_ready;
  logic [DataWidth*NumData-1:0]  in_data;
  logic [NumData-1:0]            in_mask;
  logic                          out_valid;
  logic                          out_ready;
  logic [DataWidth-1:0]          out_data;
  logic [CtrlWidth-1:0]          out_sel;
  logic                          out_last;

  modport master (
    output in_valid, in_data, in_mask, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );

  modport slave (
    input  in_valid, in_data, in_mask, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );

endinterface

// File: rtl/mux_sequencer_mux.sv
// N:1 word multiplexer: picks word ctrl_in out of a packed vector of NumData words.
module mux_sequencer_mux #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned NumData   = 16,
  parameter int unsigned CtrlWidth = 4
) (
  input  logic [DataWidth*NumData-1:0] data_in,
  input  logic [CtrlWidth-1:0]         ctrl_in,
  output logic [DataWidth-1:0]         data_out
);

  always_comb begin
    data_out = '0;
    for (int i = 0; i < int'(NumData); i++) begin
      if (ctrl_in == CtrlWidth'(i)) data_out = data_in[i*DataWidth +: DataWidth];
    end
  end

endmodule

// File: rtl/mux_sequencer.sv
// Serialises one masked vector of words onto a single valid/ready word stream,
// walking the set lanes in ascending order and driving the word mux select.
module mux_sequencer
  import mux_sequencer_pkg::*;
#(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned NumData   = 16
) (
  input  logic           clk,
  input  logic           reset,
  mux_sequencer_if.slave bus
);

  localparam int unsigned CtrlWidth = ctrl_width(NumData);

  state_e                       state_q, state_d;
  logic [DataWidth*NumData-1:0] data_q, data_d;
  logic [NumData-1:0]           mask_q, mask_d;
  logic [NumData-1:0]           mask_rest;
  logic [CtrlWidth-1:0]         sel_q, sel_d;
  logic [DataWidth-1:0]         out_data;
  logic                         in_ready;

  // Lanes still pending once the current word is taken.
  always_comb begin
    mask_rest        = mask_q;
    mask_rest[sel_q] = 1'b0;
  end

  assign in_ready      = (state_q == StIdle) && !reset;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StSend);
  assign bus.out_last  = (state_q == StSend) && (mask_rest == '0);
  assign bus.out_sel   = sel_q;
  assign bus.out_data  = out_data;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready) begin
          data_d = bus.in_data;
          mask_d = bus.in_mask;
          // An empty mask is accepted and dropped without producing a word.
          if (bus.in_mask != '0) begin
            state_d = StSend;
            sel_d   = CtrlWidth'(lowest_set(MaxLanes'(bus.in_mask)));
          end
        end
      end
      StSend: begin
        if (bus.out_ready) begin
          mask_d = mask_rest;
          if (mask_rest == '0) begin
            state_d = StIdle;
          end else begin
            sel_d = CtrlWidth'(lowest_set(MaxLanes'(mask_rest)));
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      mask_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
    end
  end

  mux_sequencer_mux #(
    .DataWidth (DataWidth),
    .NumData   (NumData),
    .CtrlWidth (CtrlWidth)
  ) u_mux (
    .data_in  (data_q),
    .ctrl_in  (sel_q),
    .data_out (out_data)
  );

endmodule
